fetch_queue: RTL and testbench

- Front-end stage of the Tomasulo core: walks the program counter over instruction memory and buffers fetched words in a DEPTH-entry in-order instruction queue.
- Presents the head entry, pre-split into opcode/rd/rs1/rs2 fields, to the issue stage (reservation stations / ROB allocation) using a valid/ready handshake.
- Supports redirect/flush so a later stage can restart fetch at a new PC.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Front-end fetch stage: steps the PC through instruction memory and buffers
// fetched words in an in-order circular queue.
// The head entry is presented pre-decoded to the issue stage over a valid/ready handshake.
module fetch_queue #(
    parameter int INSTR_W  = 16,
    parameter int PC_W     = 4,
    parameter int DEPTH    = 4,
    parameter int PROG_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]       imem_data,
    input  logic                     flush,
    input  logic [PC_W-1:0]          flush_pc,
    output logic                     iq_valid,
    input  logic                     iq_ready,
    output logic [INSTR_W-1:0]       iq_instr,
    output logic [PC_W-1:0]          iq_pc,
    output logic [3:0]               iq_op,
    output logic [3:0]               iq_rd,
    output logic [3:0]               iq_rs1,
    output logic [3:0]               iq_rs2,
    output logic                     iq_illegal,
    output logic [$clog2(DEPTH):0]   iq_count,
    output logic                     fetch_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so PROG_LEN == 2**PC_W is still reachable as an end address.
    localparam logic [PC_W:0] PROG_END = (PC_W+1)'(PROG_LEN);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               done_q, done_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PC_W-1:0]    pc_mem_q [DEPTH];

    logic               has_entry;
    logic               push;
    logic               pop;
    logic [PC_W:0]      pc_inc;
    logic [INSTR_W-1:0] head_instr;

    assign has_entry = (count_q != '0);
    assign pop       = has_entry & iq_ready & ~flush;
    assign push      = fetch_en & ~done_q & ~flush & ((count_q < CNT_W'(DEPTH)) | pop);
    assign pc_inc    = {1'b0, pc_q} + (PC_W+1)'(1);

    always_comb begin
        pc_d    = pc_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            pc_d    = flush_pc;
            done_d  = ({1'b0, flush_pc} == PROG_END);
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_inc[PC_W-1:0];
                done_d = (pc_inc == PROG_END);
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            done_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only observed while counted.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_q == PTR_W'(gi))) begin
                    instr_mem_q[gi] <= imem_data;
                    pc_mem_q[gi]    <= pc_q;
                end
            end
        end
    endgenerate

    assign head_instr = has_entry ? instr_mem_q[head_q] : '0;

    assign imem_addr  = pc_q;
    assign iq_valid   = has_entry;
    assign iq_instr   = head_instr;
    assign iq_pc      = has_entry ? pc_mem_q[head_q] : '0;
    assign iq_op      = head_instr[INSTR_W-1 -: 4];
    assign iq_rd      = head_instr[INSTR_W-5 -: 4];
    assign iq_rs1     = head_instr[INSTR_W-9 -: 4];
    assign iq_rs2     = head_instr[INSTR_W-13 -: 4];
    assign iq_illegal = has_entry & (iq_op > 4'b0101);
    assign iq_count   = count_q;
    assign fetch_done = done_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (PROG_LEN=6): stimulus queues expected head
// entries, an independent monitor pops and compares on every accepted handshake.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [3:0]  imem_addr;
    logic [15:0] imem_data;
    logic        flush;
    logic [3:0]  flush_pc;
    logic        iq_valid;
    logic        iq_ready;
    logic [15:0] iq_instr;
    logic [3:0]  iq_pc;
    logic [3:0]  iq_op;
    logic [3:0]  iq_rd;
    logic [3:0]  iq_rs1;
    logic [3:0]  iq_rs2;
    logic        iq_illegal;
    logic [2:0]  iq_count;
    logic        fetch_done;

    logic [15:0] imem [16];

    typedef struct {
        logic [3:0]  pc;
        logic [15:0] instr;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   pop_count = 0;

    fetch_queue #(
        .INSTR_W  (16),
        .PC_W     (4),
        .DEPTH    (4),
        .PROG_LEN (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .iq_valid   (iq_valid),
        .iq_ready   (iq_ready),
        .iq_instr   (iq_instr),
        .iq_pc      (iq_pc),
        .iq_op      (iq_op),
        .iq_rd      (iq_rd),
        .iq_rs1     (iq_rs1),
        .iq_rs2     (iq_rs2),
        .iq_illegal (iq_illegal),
        .iq_count   (iq_count),
        .fetch_done (fetch_done)
    );

    assign imem_data = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] pc, input logic [15:0] instr, input logic [3:0] op,
                            input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                            input logic ill);
        exp_t e;
        e.pc = pc; e.instr = instr; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.ill = ill;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (fetch_done && !iq_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Monitor: a handshake seen here is consumed at the next rising edge.
    always @(negedge clk) begin
        if (!rst && !flush && iq_valid && iq_ready) begin
            pop_count++;
            $display("pop %0d: pc=%0d instr=%h op=%0h rd=%0h rs1=%0h rs2=%0h ill=%0b",
                     pop_count, iq_pc, iq_instr, iq_op, iq_rd, iq_rs1, iq_rs2, iq_illegal);
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("pop_pc",    32'(iq_pc),      32'(e_mon.pc));
                check("pop_instr", 32'(iq_instr),   32'(e_mon.instr));
                check("pop_op",    32'(iq_op),      32'(e_mon.op));
                check("pop_rd",    32'(iq_rd),      32'(e_mon.rd));
                check("pop_rs1",   32'(iq_rs1),     32'(e_mon.rs1));
                check("pop_rs2",   32'(iq_rs2),     32'(e_mon.rs2));
                check("pop_ill",   32'(iq_illegal), 32'(e_mon.ill));
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = 16'h1000 + 16'(i);
        imem[9]  = 16'h2109;
        rst      = 1'b1;
        fetch_en = 1'b0;
        flush    = 1'b0;
        flush_pc = 4'd0;
        iq_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("txn reset: count=%0d valid=%0b addr=%0d", iq_count, iq_valid, imem_addr);
        check("rst_count", 32'(iq_count),   32'd0);
        check("rst_valid", 32'(iq_valid),   32'd0);
        check("rst_instr", 32'(iq_instr),   32'd0);
        check("rst_addr",  32'(imem_addr),  32'd0);
        check("rst_done",  32'(fetch_done), 32'd0);

        // Fill to full with issue stalled
        @(posedge clk); #1 fetch_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("txn fill: count=%0d head=%h pc=%0d", iq_count, iq_instr, iq_pc);
        check("fill_count", 32'(iq_count),  32'd4);
        check("fill_addr",  32'(imem_addr), 32'd4);
        check("fill_instr", 32'(iq_instr),  32'h1000);
        check("fill_pc",    32'(iq_pc),     32'd0);
        check("fill_op",    32'(iq_op),     32'd1);
        @(posedge clk);
        @(negedge clk);
        check("full_hold_addr", 32'(imem_addr), 32'd4);

        for (int i = 0; i < 6; i++)
            push_exp(4'(i), 16'h1000 + 16'(i), 4'h1, 4'h0, 4'h0, 4'(i), 1'b0);

        // Single-cycle pop while full
        @(posedge clk); #1 iq_ready = 1'b1;
        @(posedge clk); #1 iq_ready = 1'b0;
        @(negedge clk);
        $display("txn full_pop: count=%0d head=%h addr=%0d", iq_count, iq_instr, imem_addr);
        check("fullpop_count", 32'(iq_count),  32'd4);
        check("fullpop_instr", 32'(iq_instr),  32'h1001);
        check("fullpop_pc",    32'(iq_pc),     32'd1);
        check("fullpop_addr",  32'(imem_addr), 32'd5);

        // Stream to program end
        @(posedge clk); #1 iq_ready = 1'b1;
        wait_drain("stream_drain");
        $display("txn stream: pops=%0d done=%0b addr=%0d", pop_count, fetch_done, imem_addr);
        check("stream_pops",  32'(pop_count),     32'd6);
        check("stream_left",  32'(exp_q.size()),  32'd0);
        check("stream_addr",  32'(imem_addr),     32'd6);
        check("stream_count", 32'(iq_count),      32'd0);
        check("stream_instr", 32'(iq_instr),      32'd0);
        @(posedge clk); #1 iq_ready = 1'b0;

        // Field split and illegal opcode
        imem[2] = 16'h5321;
        imem[3] = 16'h7000;
        @(posedge clk); #1 flush = 1'b1; flush_pc = 4'd2;
        @(posedge clk); #1 flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("txn fields: head=%h op=%0h rd=%0h rs1=%0h rs2=%0h ill=%0b",
                 iq_instr, iq_op, iq_rd, iq_rs1, iq_rs2, iq_illegal);
        check("fld_done",  32'(fetch_done), 32'd0);
        check("fld_count", 32'(iq_count),   32'd3);
        check("fld_pc",    32'(iq_pc),      32'd2);
        check("fld_op",    32'(iq_op),      32'd5);
        check("fld_rd",    32'(iq_rd),      32'd3);
        check("fld_rs1",   32'(iq_rs1),     32'd2);
        check("fld_rs2",   32'(iq_rs2),     32'd1);
        check("fld_ill",   32'(iq_illegal), 32'd0);
        push_exp(4'd2, 16'h5321, 4'h5, 4'h3, 4'h2, 4'h1, 1'b0);
        push_exp(4'd3, 16'h7000, 4'h7, 4'h0, 4'h0, 4'h0, 1'b1);
        push_exp(4'd4, 16'h1004, 4'h1, 4'h0, 4'h0, 4'h4, 1'b0);
        push_exp(4'd5, 16'h1005, 4'h1, 4'h0, 4'h0, 4'h5, 1'b0);
        @(posedge clk); #1 iq_ready = 1'b1;
        wait_drain("fld_drain");
        check("fld_pops", 32'(pop_count),    32'd10);
        check("fld_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1 iq_ready = 1'b0;

        // Flush with 3 queued entries and a simultaneous ready
        @(posedge clk); #1 flush = 1'b1; flush_pc = 4'd0;
        @(posedge clk); #1 flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fl_pre_count", 32'(iq_count), 32'd3);
        flush = 1'b1; flush_pc = 4'd9; iq_ready = 1'b1;
        @(posedge clk); #1 flush = 1'b0; iq_ready = 1'b0;
        @(negedge clk);
        $display("txn flush: count=%0d valid=%0b addr=%0d", iq_count, iq_valid, imem_addr);
        check("fl_count", 32'(iq_count),  32'd0);
        check("fl_valid", 32'(iq_valid),  32'd0);
        check("fl_addr",  32'(imem_addr), 32'd9);
        @(posedge clk);
        @(negedge clk);
        $display("txn refetch: head=%h pc=%0d", iq_instr, iq_pc);
        check("fl_head_valid", 32'(iq_valid), 32'd1);
        check("fl_head_pc",    32'(iq_pc),    32'd9);
        check("fl_head_instr", 32'(iq_instr), 32'h2109);
        check("fl_pops",       32'(pop_count), 32'd10);

        // Reset mid-stream with 2 entries queued
        @(posedge clk); #1 flush = 1'b1; flush_pc = 4'd0;
        @(posedge clk); #1 flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mr_pre_count", 32'(iq_count), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; fetch_en = 1'b0;
        @(negedge clk);
        $display("txn mid_reset: count=%0d valid=%0b addr=%0d done=%0b",
                 iq_count, iq_valid, imem_addr, fetch_done);
        check("mr_addr",  32'(imem_addr),  32'd0);
        check("mr_count", 32'(iq_count),   32'd0);
        check("mr_valid", 32'(iq_valid),   32'd0);
        check("mr_done",  32'(fetch_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
